// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment scan controller
package seg7_pkg;
    localparam int NUM_DIGITS = 4;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;
    typedef enum logic {BLANK, SHOW} state_t;
    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } disp_t;
    function automatic logic [NUM_DIGITS-1:0] anode(input logic [1:0] i);
        return ~(4'b0001 << i);
    endfunction
endpackage

// File: rtl/refresh_tick_gen.sv
// refresh_tick_gen: per-digit slot counter with slot-end and dead-time-end strobes
module refresh_tick_gen #(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 1000,
    localparam int CW = $clog2(REFRESH_DIV)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [CW-1:0] cnt,
    output logic          slot_end,
    output logic          dead_end
);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DLAST = CW'(DEAD_CYCLES - 1);
    assign slot_end = cnt == LAST;
    // no dead time means the blanking phase never ends because it never starts
    assign dead_end = (DEAD_CYCLES != 0) && (cnt == DLAST);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else cnt <= slot_end ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: double-buffered 4-digit common-anode display scanner
// with per-slot blanking gap and frame-aligned buffer swap
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    input  logic        load,
    output logic        pending,
    output logic [3:0]  nibble_out,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_done
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
    localparam state_t IDLE_STATE = (DEAD_CYCLES == 0) ? SHOW : BLANK;
    logic [CW-1:0] cnt;
    logic          slot_end, dead_end, boundary, lit;
    logic [1:0]    idx;
    state_t        state;
    disp_t         s, a, din;
    assign din = '{digits: digits_in, dp: dp_in, blank: blank_in};
    assign boundary = (idx == 2'd3) && (cnt == LAST);
    assign lit = (state == SHOW) && !a.blank[idx];
    refresh_tick_gen #(.REFRESH_DIV(REFRESH_DIV), .DEAD_CYCLES(DEAD_CYCLES)) u_tick (
        .clk(clk),
        .reset(reset),
        .cnt(cnt),
        .slot_end(slot_end),
        .dead_end(dead_end)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            state      <= IDLE_STATE;
            s          <= '0;
            a          <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            nibble_out <= '0;
            an         <= AN_OFF;
            dp         <= 1'b1;
        end else begin
            idx   <= slot_end ? idx + 2'd1 : idx;
            state <= slot_end ? IDLE_STATE : (dead_end ? SHOW : state);
            if (load) s <= din;
            // a load landing on the boundary bypasses staging so it is not a frame late
            if (boundary && (load || pending)) a <= load ? din : s;
            pending    <= boundary ? 1'b0 : (load | pending);
            frame_done <= boundary;
            nibble_out <= a.digits[{idx, 2'b00} +: 4];
            an         <= lit ? anode(idx) : AN_OFF;
            dp         <= lit ? ~a.dp[idx] : 1'b1;
        end
    end
endmodule
